// File: rtl/scroll_controller.sv
// Horizontal world-scroll controller: advances the camera offset when the
// player pushes past a screen threshold, clamps at the level end, then runs
// the castle-entry sequence and flags level completion.
module scroll_controller #(
    parameter logic [9:0] SCROLL_THRESH = 10'd320,
    parameter logic [9:0] MAX_PROCESS   = 10'd700,
    parameter logic [9:0] DOOR_OFFSET   = 10'd24,
    parameter logic [7:0] ENTER_FRAMES  = 8'd60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       restart,
    input  logic [9:0] player_x,
    input  logic [3:0] player_dx,
    input  logic [9:0] castle_x,
    output logic [9:0] process,
    output logic       player_hold,
    output logic       entering,
    output logic       level_done
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        SCROLL = 2'd0,
        LOCKED = 2'd1,
        ENTER  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               fc_d;
    logic               tick;
    logic               at_thresh;
    logic               castle_hit;
    logic [POS_W:0]     scroll_sum;
    logic [POS_W-1:0]   scroll_next;

    // Frame-strobe edge detect plus the scroll and castle-door arithmetic.
    always_comb begin
        tick        = frame_clk & ~fc_d;
        at_thresh   = (player_x >= SCROLL_THRESH);
        scroll_sum  = {1'b0, process} + (POS_W+1)'(player_dx);
        scroll_next = (scroll_sum >= {1'b0, MAX_PROCESS}) ? MAX_PROCESS
                                                          : scroll_sum[POS_W-1:0];
        castle_hit  = (({1'b0, player_x} + {1'b0, process}) >=
                       ({1'b0, castle_x} + {1'b0, DOOR_OFFSET}));
    end

    // Camera / entry-sequence FSM with registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_d        <= 1'b1;
            state       <= SCROLL;
            count       <= '0;
            process     <= '0;
            player_hold <= 1'b0;
            entering    <= 1'b0;
            level_done  <= 1'b0;
        end else begin
            fc_d <= frame_clk;
            if (restart) begin
                state       <= SCROLL;
                count       <= '0;
                process     <= '0;
                player_hold <= at_thresh;
                entering    <= 1'b0;
                level_done  <= 1'b0;
            end else begin
                case (state)
                    SCROLL: begin
                        player_hold <= at_thresh;
                        if (tick) begin
                            // Reaching the door takes priority over scrolling.
                            if (castle_hit) begin
                                state       <= ENTER;
                                count       <= '0;
                                player_hold <= 1'b1;
                                entering    <= 1'b1;
                            end else if (at_thresh) begin
                                process <= scroll_next;
                                if (scroll_next == MAX_PROCESS) begin
                                    state       <= LOCKED;
                                    player_hold <= 1'b0;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        player_hold <= 1'b0;
                        if (tick && castle_hit) begin
                            state       <= ENTER;
                            count       <= '0;
                            player_hold <= 1'b1;
                            entering    <= 1'b1;
                        end
                    end
                    ENTER: begin
                        player_hold <= 1'b1;
                        entering    <= 1'b1;
                        if (tick) begin
                            if (count == ENTER_FRAMES - 8'd1) begin
                                state      <= DONE;
                                entering   <= 1'b0;
                                level_done <= 1'b1;
                            end else begin
                                count <= count + 8'd1;
                            end
                        end
                    end
                    default: begin
                        player_hold <= 1'b1;
                        entering    <= 1'b0;
                        level_done  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller: a table of stimulus/expectation
// records walks the level end to end, then hand sequences cover restart,
// castle priority, strobe latency and reset with frame_clk held high.
module tb_scroll_controller;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       restart;
    logic [9:0] player_x;
    logic [3:0] player_dx;
    logic [9:0] castle_x;
    logic [9:0] process;
    logic       player_hold;
    logic       entering;
    logic       level_done;

    int n_compared;
    int n_mismatched;

    typedef struct {
        string      name;
        logic [9:0] process;
        logic       hold;
        logic       entering;
        logic       done;
    } exp_t;

    typedef struct {
        string      name;
        logic [9:0] px;
        logic [3:0] dx;
        logic [9:0] cx;
        int         ticks;
        logic [9:0] e_process;
        logic       e_hold;
        logic       e_entering;
        logic       e_done;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[11];

    scroll_controller dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .restart     (restart),
        .player_x    (player_x),
        .player_dx   (player_dx),
        .castle_x    (castle_x),
        .process     (process),
        .player_hold (player_hold),
        .entering    (entering),
        .level_done  (level_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic push_exp(input string name, input logic [9:0] p,
                            input logic h, input logic e, input logic d);
        exp_t x;
        x.name = name; x.process = p; x.hold = h; x.entering = e; x.done = d;
        sb_q.push_back(x);
    endtask

    task automatic cmp1(input string name, input string field,
                        input logic [9:0] act, input logic [9:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
        end
    endtask

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic check_pop();
        exp_t x;
        if (sb_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard: empty queue, got process=%0d expected an entry", process);
        end else begin
            x = sb_q.pop_front();
            cmp1(x.name, "process",     process,            x.process);
            cmp1(x.name, "player_hold", 10'(player_hold),   10'(x.hold));
            cmp1(x.name, "entering",    10'(entering),      10'(x.entering));
            cmp1(x.name, "level_done",  10'(level_done),    10'(x.done));
        end
    endtask

    // Each tick: one cycle of frame_clk high, one low; returns at the negedge
    // just after the tick edge so outputs are already updated.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_clk = 1'b1;
            @(negedge Clk) frame_clk = 1'b0;
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // name, px, dx, cx, ticks, process, hold, entering, done
        vecs[0]  = '{"reset_state",  10'd100, 4'd4,  10'd1000, 0,  10'd0,   1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"below_thresh", 10'd100, 4'd4,  10'd1000, 10, 10'd0,   1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"scroll_5",     10'd320, 4'd4,  10'd1000, 5,  10'd20,  1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"scroll_45x15", 10'd320, 4'd15, 10'd1000, 45, 10'd695, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"scroll_to698", 10'd320, 4'd3,  10'd1000, 1,  10'd698, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"clamp_700",    10'd320, 4'd15, 10'd1000, 1,  10'd700, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"locked_hold",  10'd320, 4'd15, 10'd1000, 3,  10'd700, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"enter_door",   10'd224, 4'd15, 10'd900,  1,  10'd700, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"enter_59",     10'd224, 4'd15, 10'd900,  59, 10'd700, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"done_60",      10'd224, 4'd15, 10'd900,  1,  10'd700, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{"done_stays",   10'd224, 4'd15, 10'd900,  5,  10'd700, 1'b1, 1'b0, 1'b1};

        Reset     = 1'b1;
        frame_clk = 1'b0;
        restart   = 1'b0;
        player_x  = 10'd100;
        player_dx = 4'd4;
        castle_x  = 10'd1000;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Main walk through the level.
        for (int i = 0; i < 11; i++) begin
            player_x  = vecs[i].px;
            player_dx = vecs[i].dx;
            castle_x  = vecs[i].cx;
            push_exp(vecs[i].name, vecs[i].e_process, vecs[i].e_hold,
                     vecs[i].e_entering, vecs[i].e_done);
            tick_n(vecs[i].ticks);
            if (vecs[i].ticks == 0) @(negedge Clk);
            check_pop();
        end

        // Restart out of DONE.
        push_exp("restart_done", 10'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk) restart = 1'b1;
        @(negedge Clk) restart = 1'b0;
        check_pop();

        // Door already reached on first tick: entry wins, no scroll step.
        player_x = 10'd320; player_dx = 4'd4; castle_x = 10'd0;
        push_exp("castle_prio", 10'd0, 1'b1, 1'b1, 1'b0);
        tick_n(1);
        check_pop();
        tick_n(3);

        // Restart and tick on the same edge inside ENTER.
        push_exp("restart_tick", 10'd0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk) begin frame_clk = 1'b1; restart = 1'b1; end
        @(negedge Clk) begin frame_clk = 1'b0; restart = 1'b0; end
        check_pop();

        // Full 60-frame entry again after restart.
        push_exp("reenter", 10'd0, 1'b1, 1'b1, 1'b0);
        tick_n(1);
        check_pop();
        push_exp("reenter_59", 10'd0, 1'b1, 1'b1, 1'b0);
        tick_n(59);
        check_pop();
        push_exp("reenter_done", 10'd0, 1'b1, 1'b0, 1'b1);
        tick_n(1);
        check_pop();

        // Reset from DONE with frame_clk held high through release.
        player_x = 10'd320; player_dx = 4'd4; castle_x = 10'd1000;
        @(negedge Clk) begin Reset = 1'b1; frame_clk = 1'b1; end
        @(negedge Clk);
        push_exp("reset_mid_done", 10'd0, 1'b0, 1'b0, 1'b0);
        check_pop();
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        push_exp("fc_high_release", 10'd0, 1'b1, 1'b0, 1'b0);
        check_pop();

        // One real tick: update is not visible before the edge, visible after.
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk) frame_clk = 1'b1;
        push_exp("pre_edge", 10'd0, 1'b1, 1'b0, 1'b0);
        check_pop();
        @(negedge Clk) frame_clk = 1'b0;
        push_exp("post_edge", 10'd4, 1'b1, 1'b0, 1'b0);
        check_pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
